// File: rtl/sl_transmitter.sv
// SL word transmitter: serialises a host word LSB-first with odd parity and a stop symbol
// onto the two-wire zeroes/ones link, sharing the receiver's config layout.
module sl_transmitter #(
   parameter int unsigned CONFIG_WIDTH = 16,
   parameter int unsigned STATUS_WIDTH = 16,
   parameter int unsigned LOW_CYCLES   = 16,
   parameter int unsigned HIGH_CYCLES  = 16,
   parameter int unsigned GAP_CYCLES   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [CONFIG_WIDTH-1:0] wr_config_w,
   input  logic                    wr_enable,
   output logic [CONFIG_WIDTH-1:0] r_config_w,
   output logic [STATUS_WIDTH-1:0] status_w,
   output logic                    tx_done,
   output logic                    serial_line_zeroes,
   output logic                    serial_line_ones
);
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FRAME_W = DATA_W + 1;
   localparam int unsigned BIT_W   = 6;
   localparam int unsigned LH_MAX  = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
   localparam int unsigned MAX_CYC = (LH_MAX > GAP_CYCLES) ? LH_MAX : GAP_CYCLES;
   localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CONFIG_WIDTH-1:0] CFG_RESET = CONFIG_WIDTH'(16'h0010);

   typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, GAP} state_t;

   state_t                  state_q, state_d;
   logic [CYC_W-1:0]        cyc_q, cyc_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [BIT_W-1:0]        bq_q, bq_d;
   logic [FRAME_W-1:0]      frame_q, frame_d;
   logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
   logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                    tx_done_d, tx_ready_d, zeroes_d, ones_d;

   logic [BIT_W-1:0]        cfg_bq, wr_bq;
   logic                    cfg_pei, parity, wr_ok;
   logic [FRAME_W-1:0]      data_mask, data_ext, frame_load;

   assign cfg_bq  = cfg_q[6:1];
   assign cfg_pei = cfg_q[9];
   assign wr_bq   = wr_config_w[6:1];
   assign wr_ok   = (wr_bq >= BIT_W'(8)) && (wr_bq <= BIT_W'(32)) && !wr_bq[0];

   // Frame image: masked data bits with the parity bit placed just above the last data bit
   always_comb begin
      data_mask  = (FRAME_W'(1) << cfg_bq) - FRAME_W'(1);
      data_ext   = {1'b0, tx_data} & data_mask;
      parity     = ~(^data_ext) ^ cfg_pei;
      frame_load = data_ext | (FRAME_W'(parity) << cfg_bq);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= IDLE;
         cyc_q              <= '0;
         bit_q              <= '0;
         bq_q               <= '0;
         frame_q            <= '0;
         cfg_q              <= CFG_RESET;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
         err_q              <= 1'b0;
         tx_done            <= 1'b0;
         tx_ready           <= 1'b1;
         serial_line_zeroes <= 1'b1;
         serial_line_ones   <= 1'b1;
      end else begin
         state_q            <= state_d;
         cyc_q              <= cyc_d;
         bit_q              <= bit_d;
         bq_q               <= bq_d;
         frame_q            <= frame_d;
         cfg_q              <= cfg_d;
         busy_q             <= busy_d;
         done_q             <= done_d;
         err_q              <= err_d;
         tx_done            <= tx_done_d;
         tx_ready           <= tx_ready_d;
         serial_line_zeroes <= zeroes_d;
         serial_line_ones   <= ones_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      bit_d     = bit_q;
      bq_d      = bq_q;
      frame_d   = frame_q;
      cfg_d     = cfg_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      tx_done_d = 1'b0;
      zeroes_d  = 1'b1;
      ones_d    = 1'b1;

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               state_d = BIT_LOW;
               cyc_d   = '0;
               bit_d   = '0;
               bq_d    = cfg_bq;
               frame_d = frame_load;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         BIT_LOW: begin
            if (cyc_q == CYC_W'(LOW_CYCLES - 1)) begin
               state_d = BIT_HIGH;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         BIT_HIGH: begin
            if (cyc_q == CYC_W'(HIGH_CYCLES - 1)) begin
               cyc_d = '0;
               if (bit_q == bq_q) begin
                  state_d = STOP_LOW;
               end else begin
                  state_d = BIT_LOW;
                  bit_d   = bit_q + BIT_W'(1);
                  frame_d = frame_q >> 1;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         STOP_LOW: begin
            if (cyc_q == CYC_W'(LOW_CYCLES - 1)) begin
               state_d = GAP;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         GAP: begin
            if (cyc_q == CYC_W'(GAP_CYCLES - 1)) begin
               state_d   = IDLE;
               cyc_d     = '0;
               tx_done_d = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Config writes only land between frames; an accept on the same edge keeps the old snapshot
      if (wr_enable) begin
         if ((state_q == IDLE) && wr_ok) begin
            cfg_d = wr_config_w;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end

      // Lines follow the next state so they come straight from flops
      case (state_d)
         BIT_LOW: begin
            zeroes_d = frame_d[0];
            ones_d   = ~frame_d[0];
         end
         STOP_LOW: begin
            zeroes_d = 1'b0;
            ones_d   = 1'b0;
         end
         default: ;
      endcase

      tx_ready_d = (state_d == IDLE);
   end

   assign r_config_w = cfg_q;
   assign status_w   = {(STATUS_WIDTH - 3)'(0), err_q, done_q, busy_q};

endmodule
